bus_transfer_unit: RTL and testbench

- Downstream consumer of the 7-master round-robin arbiter's one-hot grant `grt[7:1]`.
- Latches the granted master's address, write data and write-enable, then performs one access on the shared memory bus with a ready handshake.
- Returns a one-cycle acknowledge plus read data to that master, then waits for the master to release its request before accepting a new grant.
- Sits between the arbiter and the MiniComputer memory/IO bus.

---
 rtl/bus_transfer_unit_pkg.sv | 14 +
 rtl/bus_transfer_unit_grant_encoder_3b.sv | 25 ++
 rtl/bus_transfer_unit.sv | 120 ++++++++++++
 tb/tb_bus_transfer_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_transfer_unit_pkg.sv
// bus_transfer_unit_pkg: shared state encodings, master count and default widths
package bus_transfer_unit_pkg;
   localparam int N_MASTERS   = 7;
   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_TIMEOUT = 15;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACCESS  = 3'd1,
      ACK     = 3'd2,
      ABORT   = 3'd3,
      RELEASE = 3'd4
   } state_e;
endpackage

// File: rtl/bus_transfer_unit_grant_encoder_3b.sv
// grant_encoder_3b: one-hot grant to 3-bit master index with validity flags
//   oh_i    : grant vector, bit i = master i (1..7)
//   idx_o   : index of the set bit (highest set bit when multi-hot)
//   valid_o : exactly one bit set
//   multi_o : more than one bit set
module grant_encoder_3b (
   input  logic [7:1] oh_i,
   output logic [2:0] idx_o,
   output logic       valid_o,
   output logic       multi_o
);
   logic [2:0] cnt;
   always_comb begin
      idx_o = '0;
      cnt   = '0;
      for (int i = 1; i <= 7; i++) begin
         if (oh_i[i]) begin
            idx_o = 3'(i);
            cnt   = cnt + 3'd1;
         end
      end
      valid_o = cnt == 3'd1;
      multi_o = cnt > 3'd1;
   end
endmodule

// File: rtl/bus_transfer_unit.sv
// bus_transfer_unit: serves one arbiter-granted master per transfer on the shared memory bus
//   Clk/Rst            : clock, synchronous active-high reset
//   grt/req            : one-hot grant and request lines of masters 1..7
//   m_addr/m_wdata/m_we: flattened per-master address, write data, write enable
//   m_ack/m_err/m_rdata: one-cycle acknowledge / timeout flag, shared read data
//   mem_*              : memory bus strobe, write enable, address, data, ready
//   busy/grt_fault     : not idle / sticky multi-hot grant seen
module bus_transfer_unit
   import bus_transfer_unit_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic [N_MASTERS:1]            grt,
   input  logic [N_MASTERS:1]            req,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
   input  logic [N_MASTERS:1]            m_we,
   output logic [N_MASTERS:1]            m_ack,
   output logic [N_MASTERS:1]            m_err,
   output logic [DATA_W-1:0]             m_rdata,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   input  logic                          mem_ready,
   output logic                          busy,
   output logic                          grt_fault
);
   state_e            state_q;
   logic [2:0]        idx_q;
   logic              we_q;
   logic [3:0]        cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [2:0]        g_idx;
   logic              g_valid;
   logic              g_multi;
   logic [ADDR_W-1:0] addr_a [N_MASTERS:1];
   logic [DATA_W-1:0] wdata_a [N_MASTERS:1];
   grant_encoder_3b u_enc (
      .oh_i    (grt),
      .idx_o   (g_idx),
      .valid_o (g_valid),
      .multi_o (g_multi)
   );
   for (genvar i = 1; i <= N_MASTERS; i++) begin : g_unpack
      assign addr_a[i]  = m_addr[i*ADDR_W-1 -: ADDR_W];
      assign wdata_a[i] = m_wdata[i*DATA_W-1 -: DATA_W];
   end
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         we_q      <= 1'b0;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         m_ack     <= '0;
         m_err     <= '0;
         m_rdata   <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         busy      <= 1'b0;
         grt_fault <= 1'b0;
      end else begin
         m_ack <= '0;
         m_err <= '0;
         unique case (state_q)
            IDLE: begin
               if (g_multi) grt_fault <= 1'b1;
               else if (g_valid && req[g_idx]) begin
                  idx_q   <= g_idx;
                  we_q    <= m_we[g_idx];
                  addr_q  <= addr_a[g_idx];
                  wdata_q <= wdata_a[g_idx];
                  cnt_q   <= '0;
                  mem_en  <= 1'b1;
                  mem_we  <= m_we[g_idx];
                  busy    <= 1'b1;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  if (!we_q) m_rdata <= mem_rdata;
                  m_ack[idx_q] <= 1'b1;
                  mem_en       <= 1'b0;
                  mem_we       <= 1'b0;
                  state_q      <= ACK;
               end else begin
                  cnt_q <= cnt_q == 4'hF ? cnt_q : cnt_q + 4'd1;
                  // abort on the cycle the count would reach the limit
                  if (cnt_q + 4'd1 == 4'(TIMEOUT)) begin
                     m_err[idx_q] <= 1'b1;
                     mem_en       <= 1'b0;
                     mem_we       <= 1'b0;
                     state_q      <= ABORT;
                  end
               end
            end
            ACK, ABORT: state_q <= RELEASE;
            RELEASE: begin
               // a held request would otherwise be served twice
               if (!req[idx_q] || !grt[idx_q]) begin
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_transfer_unit.sv
// tb_bus_transfer_unit: scoreboard bench for bus_transfer_unit with directed transfers
module tb_bus_transfer_unit;
   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [7:1]  grt = '0;
   logic [7:1]  req = '0;
   logic [55:0] m_addr = '0;
   logic [55:0] m_wdata = '0;
   logic [7:1]  m_we = '0;
   logic [7:1]  m_ack;
   logic [7:1]  m_err;
   logic [7:0]  m_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        busy;
   logic        grt_fault;
   typedef struct {
      logic [7:1] ack;
      logic [7:1] err;
      logic [7:0] rd;
   } exp_t;
   exp_t       sb[$];
   exp_t       e;
   int         total = 0;
   int         bad = 0;
   int         en_cnt = 0;
   logic [7:0] exp_addr = '0;
   logic [7:0] exp_wdata = '0;
   logic       exp_we = 1'b0;
   bus_transfer_unit dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .grt       (grt),
      .req       (req),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_we      (m_we),
      .m_ack     (m_ack),
      .m_err     (m_err),
      .m_rdata   (m_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .busy      (busy),
      .grt_fault (grt_fault)
   );
   always #5 Clk = ~Clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, a, x);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask
   always @(negedge Clk) begin
      if (mem_en) begin
         en_cnt++;
         chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
         chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
         chk("mem_we", 32'(mem_we), 32'(exp_we));
      end
      if (m_ack != '0 || m_err != '0) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: ack=%b err=%b want none", m_ack, m_err);
         end else begin
            e = sb.pop_front();
            chk("m_ack", 32'(m_ack), 32'(e.ack));
            chk("m_err", 32'(m_err), 32'(e.err));
            chk("m_rdata", 32'(m_rdata), 32'(e.rd));
         end
      end
   end
   task automatic xfer(input int m, input logic [7:0] a, input logic [7:0] d, input logic we,
                       input int rdy_dly, input logic [7:0] rd, input logic is_err,
                       input logic [7:0] exp_rd, input int exp_en, input int exp_lat, input int hold);
      exp_t x;
      int lat = 0;
      int acc = 0;
      logic done = 1'b0;
      x.ack = '0;
      x.err = '0;
      if (is_err) x.err[m] = 1'b1;
      else x.ack[m] = 1'b1;
      x.rd = exp_rd;
      sb.push_back(x);
      exp_addr  = a;
      exp_wdata = d;
      exp_we    = we;
      en_cnt    = 0;
      m_addr[m*8-1 -: 8]  = a;
      m_wdata[m*8-1 -: 8] = d;
      m_we[m]   = we;
      mem_rdata = rd;
      mem_ready = rdy_dly == 0;
      req = '0;
      req[m] = 1'b1;
      grt = '0;
      grt[m] = 1'b1;
      while (!done && lat < 40) begin
         tick(1);
         lat++;
         if (mem_en) begin
            acc++;
            mem_ready = acc > rdy_dly;
         end
         if (m_ack != '0 || m_err != '0) done = 1'b1;
      end
      chk("resp_seen", 32'(done), 32'd1);
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("en_cycles", 32'(en_cnt), 32'(exp_en));
      mem_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         tick(1);
         chk("hold_no_en", 32'(mem_en), 32'd0);
         chk("hold_busy", 32'(busy), 32'd1);
      end
      req = '0;
      grt = '0;
      for (int i = 0; i < 10 && busy; i++) tick(1);
      chk("busy_drop", 32'(busy), 32'd0);
   endtask
   initial begin
      int acc;
      tick(2);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_ack_err", 32'({m_ack, m_err}), 32'd0);
      chk("rst_rdata", 32'(m_rdata), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_fault", 32'(grt_fault), 32'd0);
      Rst = 1'b0;
      tick(1);
      xfer(2, 8'h3C, 8'h00, 1'b0, 0, 8'hA5, 1'b0, 8'hA5, 1, 2, 0);
      xfer(5, 8'h10, 8'h7E, 1'b1, 3, 8'h55, 1'b0, 8'hA5, 4, 5, 0);
      xfer(3, 8'h21, 8'h00, 1'b0, 0, 8'h96, 1'b0, 8'h96, 1, 2, 5);
      xfer(6, 8'hC3, 8'h00, 1'b0, 0, 8'h5A, 1'b0, 8'h5A, 1, 2, 0);
      xfer(4, 8'h44, 8'h00, 1'b0, 100, 8'hFF, 1'b1, 8'h5A, 15, 16, 0);
      en_cnt = 0;
      req = 7'b0010010;
      grt = 7'b0010010;
      tick(3);
      chk("fault_set", 32'(grt_fault), 32'd1);
      chk("fault_no_en", 32'(en_cnt), 32'd0);
      chk("fault_idle", 32'(busy), 32'd0);
      req = '0;
      grt = 7'b0000010;
      tick(2);
      chk("fault_sticky", 32'(grt_fault), 32'd1);
      grt = '0;
      Rst = 1'b1;
      tick(1);
      chk("fault_clr", 32'(grt_fault), 32'd0);
      Rst = 1'b0;
      tick(1);
      en_cnt = 0;
      exp_addr = 8'h77;
      exp_wdata = 8'h00;
      exp_we = 1'b0;
      m_addr[55:48] = 8'h77;
      m_wdata[55:48] = 8'h00;
      m_we[7] = 1'b0;
      mem_ready = 1'b0;
      req[7] = 1'b1;
      grt[7] = 1'b1;
      acc = 0;
      for (int i = 0; i < 10 && acc < 3; i++) begin
         tick(1);
         if (mem_en) acc++;
      end
      chk("mid_access", 32'(acc), 32'd3);
      Rst = 1'b1;
      req = '0;
      grt = '0;
      tick(1);
      chk("mid_rst_en", 32'({mem_en, mem_we, busy}), 32'd0);
      chk("mid_rst_resp", 32'({m_ack, m_err}), 32'd0);
      chk("mid_rst_bus", 32'({mem_addr, mem_wdata, m_rdata}), 32'd0);
      Rst = 1'b0;
      tick(20);
      chk("mid_rst_en_total", 32'(en_cnt), 32'd3);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end
endmodule
